lm_sm_seq: RTL and testbench
============================

# lm_sm_seq

Multi-cycle sequencer for IITB-RISC load-multiple (LM) and store-multiple (SM) instructions. It sits between the decode stage and the RR/EX pipeline register. When decode hands it an LM/SM, it expands the 8-bit register list into one single-register micro-op per set bit. Each micro-op carries its register number, memory-address offset and control bits. The sequencer stalls fetch/decode until the last micro-op is issued.

## Interface
Parameters: none (8 architectural registers, 16-bit datapath fixed).
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-low
- start  in  1  decode presents a valid LM/SM this cycle
- is_lm  in  1  decoded op is LM
- is_sm  in  1  decoded op is SM
- reg_list  in  8  register list; bit i selects Ri
- base_reg  in  3  Ra, the base-address register
- hold  in  1  downstream stall; freezes sequencer
- flush  in  1  squash in-flight sequence (branch/jump resolved)
- stall  out  1  freeze PC and IF/ID register
- uop_valid  out  1  micro-op outputs are valid this cycle
- uop_reg  out  3  register to load (LM) or read and store (SM)
- uop_base  out  3  latched Ra, forwarded as rs1
- uop_offset  out  16  zero-extended address offset added to Ra in EX
- uop_reg_write  out  1  micro-op writes the register file (LM)
- uop_mem_rd  out  1  micro-op reads memory (LM)
- uop_mem_write  out  1  micro-op writes memory (SM)
- uop_last  out  1  current micro-op is the final one of the sequence
- done  out  1  last micro-op accepted this cycle

## Operation
- Internal state: `state` {IDLE, ISSUE}, `mask[7:0]`, `offset[2:0]`, `mode_lm`, `base[2:0]`.
- IDLE, accept condition: start=1, is_lm XOR is_sm = 1, reg_list != 0, flush=0.
  - On accept: mask<=reg_list, offset<=0, mode_lm<=is_lm, base<=base_reg; go to ISSUE.
- IDLE, other cases:
  - start with is_lm=is_sm (both set or both clear): ignored.
  - start with reg_list=0: ignored; no micro-ops are generated and downstream treats the op as a nop.
- ISSUE, micro-op outputs (combinational from registers):
  - uop_valid = !flush.
  - uop_reg = index of the lowest set bit of mask.
  - uop_offset = {13'b0, offset}.
  - uop_last = mask has exactly one bit set.
  - uop_reg_write = uop_mem_rd = mode_lm; uop_mem_write = !mode_lm.
  - All uop_* and done outputs are gated by uop_valid.
- ISSUE, advance: when hold=0 and flush=0, clear the lowest set bit of mask and increment offset.
  - If uop_last, done=1 and state<=IDLE.
- ISSUE, hold=1: all registers hold; outputs repeat the same micro-op.
- ISSUE, flush=1: state<=IDLE, mask<=0, offset<=0; no micro-op is issued that cycle. flush overrides hold.
- stall = (state==ISSUE), taken from the registered state.
- start is not sampled in ISSUE.
- Offsets are dense (0..N-1), not the register index. Register ordering is ascending R0..R7.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, mask=0, offset=0, mode_lm=0, base=0. Every output is 0.
- Start latency: start accepted at edge E; micro-op 0 is valid in the cycle after E. stall rises with that same cycle.
- Throughput: one micro-op per cycle when hold=0. An N-bit list takes exactly N ISSUE cycles.
- End of sequence: done and uop_last are high in the final ISSUE cycle. stall is low in the following cycle, so decode advances then.
- Maximum N=8: offset reaches 7 with no wrap.
- If the sequencer returns to IDLE and start is presented in that same first IDLE cycle, the new op is accepted normally. There is no dead cycle.
- rst asserted mid-sequence aborts immediately: all outputs drop to 0 asynchronously.

## Test plan
- Reset then LM, reg_list=8'b1010_0001, base_reg=3: three cycles with uop_reg 0,5,7 and uop_offset 0,1,2.
  - uop_reg_write=uop_mem_rd=1 and uop_base=3 throughout; stall=1 for exactly 3 cycles; done on the 3rd.
- SM, reg_list=8'hFF: eight cycles with uop_reg 0..7 and offsets 0..7; uop_mem_write=1, uop_reg_write=0; uop_last only on offset 7.
- LM, reg_list=8'b0000_0110, hold=1 for 2 cycles on the first micro-op:
  - uop_reg=1 and offset 0 held for 3 cycles, then uop_reg=2 at offset 1; stall=1 for 4 cycles total.
- SM, reg_list=8'hF0, flush=1 in the 2nd ISSUE cycle:
  - only uop_reg=4 is issued; uop_valid=0 in the flush cycle; stall=0 next cycle; no done pulse.
- Invalid starts are ignored:
  - start with reg_list=0: stall stays 0, uop_valid stays 0.
  - start with is_lm=is_sm=1: same, stall and uop_valid stay 0.
  - A valid start presented in the first IDLE cycle after a done is accepted back-to-back.
- rst pulled low in the 2nd ISSUE cycle of LM 8'hFF: all outputs go to 0 immediately.
  - After rst is released, the sequencer sits in IDLE with stall=0.

Source files
------------

// File: rtl/lm_sm_seq.sv
// Load-multiple / store-multiple sequencer: expands an 8-bit register list into
// one single-register micro-op per set bit, stalling fetch/decode meanwhile.
module lm_sm_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_lm,
  input  logic        is_sm,
  input  logic [7:0]  reg_list,
  input  logic [2:0]  base_reg,
  input  logic        hold,
  input  logic        flush,
  output logic        stall,
  output logic        uop_valid,
  output logic [2:0]  uop_reg,
  output logic [2:0]  uop_base,
  output logic [15:0] uop_offset,
  output logic        uop_reg_write,
  output logic        uop_mem_rd,
  output logic        uop_mem_write,
  output logic        uop_last,
  output logic        done
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] offset_q, offset_d;
  logic       mode_lm_q, mode_lm_d;
  logic [2:0] base_q, base_d;

  logic       issue;
  logic       accept;
  logic       single;
  logic [2:0] low_idx;

  assign issue  = (state_q == StIssue);
  assign accept = start & (is_lm ^ is_sm) & (reg_list != 8'd0) & ~flush;
  assign single = (mask_q != 8'd0) && ((mask_q & (mask_q - 8'd1)) == 8'd0);

  // Scan downwards so the lowest set bit wins.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    offset_d  = offset_q;
    mode_lm_d = mode_lm_q;
    base_d    = base_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StIssue;
          mask_d    = reg_list;
          offset_d  = 3'd0;
          mode_lm_d = is_lm;
          base_d    = base_reg;
        end
      end
      StIssue: begin
        if (flush) begin
          state_d  = StIdle;
          mask_d   = 8'd0;
          offset_d = 3'd0;
        end else if (!hold) begin
          mask_d   = mask_q & (mask_q - 8'd1);
          offset_d = offset_q + 3'd1;
          if (single) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall         = issue;
    uop_valid     = issue & ~flush;
    uop_reg       = 3'd0;
    uop_base      = 3'd0;
    uop_offset    = 16'd0;
    uop_reg_write = 1'b0;
    uop_mem_rd    = 1'b0;
    uop_mem_write = 1'b0;
    uop_last      = 1'b0;
    done          = 1'b0;
    if (uop_valid) begin
      uop_reg       = low_idx;
      uop_base      = base_q;
      uop_offset    = {13'd0, offset_q};
      uop_reg_write = mode_lm_q;
      uop_mem_rd    = mode_lm_q;
      uop_mem_write = ~mode_lm_q;
      uop_last      = single;
      done          = single & ~hold;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mask_q    <= 8'd0;
      offset_q  <= 3'd0;
      mode_lm_q <= 1'b0;
      base_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      offset_q  <= offset_d;
      mode_lm_q <= mode_lm_d;
      base_q    <= base_d;
    end
  end

endmodule

// File: tb/tb_lm_sm_seq.sv
// Self-checking bench for lm_sm_seq: per-cycle vector table plus a hand-written
// asynchronous-reset sequence, compared through an expected-value queue.
module tb_lm_sm_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start, is_lm, is_sm, hold, flush;
  logic [7:0]  reg_list;
  logic [2:0]  base_reg;
  logic        stall, uop_valid, uop_reg_write, uop_mem_rd, uop_mem_write, uop_last, done;
  logic [2:0]  uop_reg, uop_base;
  logic [15:0] uop_offset;

  always #5 clk = ~clk;

  lm_sm_seq dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .is_lm         (is_lm),
    .is_sm         (is_sm),
    .reg_list      (reg_list),
    .base_reg      (base_reg),
    .hold          (hold),
    .flush         (flush),
    .stall         (stall),
    .uop_valid     (uop_valid),
    .uop_reg       (uop_reg),
    .uop_base      (uop_base),
    .uop_offset    (uop_offset),
    .uop_reg_write (uop_reg_write),
    .uop_mem_rd    (uop_mem_rd),
    .uop_mem_write (uop_mem_write),
    .uop_last      (uop_last),
    .done          (done)
  );

  // {stall, valid, reg, base, offset, reg_write, mem_rd, mem_write, last, done}
  logic [28:0] act;
  assign act = {stall, uop_valid, uop_reg, uop_base, uop_offset,
                uop_reg_write, uop_mem_rd, uop_mem_write, uop_last, done};

  typedef struct {
    string       name;
    logic        start, is_lm, is_sm;
    logic [7:0]  reg_list;
    logic [2:0]  base_reg;
    logic        hold, flush;
    logic [28:0] exp;
  } vec_t;

  localparam logic [28:0] Z = '0;

  vec_t        vecs[$];
  logic [28:0] sb[$];
  string       sb_name[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [28:0] e_uop(input logic valid, input logic [2:0] r, b, o,
                                        input logic lm, last, dn);
    if (!valid) return {1'b1, 28'd0};
    return {1'b1, 1'b1, r, b, {13'd0, o}, lm, lm, ~lm, last, dn};
  endfunction

  function automatic vec_t mk(input string n, input logic st, lm, sm, input logic [7:0] rl,
                              input logic [2:0] br, input logic hd, fl, input logic [28:0] ex);
    vec_t v;
    v.name = n; v.start = st; v.is_lm = lm; v.is_sm = sm; v.reg_list = rl;
    v.base_reg = br; v.hold = hd; v.flush = fl; v.exp = ex;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    start = v.start; is_lm = v.is_lm; is_sm = v.is_sm; reg_list = v.reg_list;
    base_reg = v.base_reg; hold = v.hold; flush = v.flush;
  endtask

  task automatic expect_push(input string n, input logic [28:0] e);
    sb.push_back(e);
    sb_name.push_back(n);
  endtask

  task automatic check_pop();
    logic [28:0] e;
    string       n;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h, required an expected entry", act);
      return;
    end
    e = sb.pop_front();
    n = sb_name.pop_front();
    if (act !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %h required %h", n, $time, act, e);
    end
  endtask

  initial begin
    drive(mk("init", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_push("reset_state", Z);
    #2 check_pop();
    rst = 1'b1;

    // LM R0,R5,R7 from base 3
    vecs.push_back(mk("lm_a1_accept", 1, 1, 0, 8'hA1, 3'd3, 0, 0, Z));
    vecs.push_back(mk("lm_a1_uop0", 0, 0, 0, 8'h00, 3'd0, 0, 0, e_uop(1, 0, 3, 0, 1, 0, 0)));
    vecs.push_back(mk("lm_a1_uop1", 0, 0, 0, 8'h00, 3'd0, 0, 0, e_uop(1, 5, 3, 1, 1, 0, 0)));
    vecs.push_back(mk("lm_a1_uop2", 0, 0, 0, 8'h00, 3'd0, 0, 0, e_uop(1, 7, 3, 2, 1, 1, 1)));
    // SM all registers, started in the first IDLE cycle after done
    vecs.push_back(mk("sm_ff_b2b_accept", 1, 0, 1, 8'hFF, 3'd2, 0, 0, Z));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("sm_ff_uop", 0, 0, 0, 8'h00, 3'd0, 0, 0,
                        e_uop(1, 3'(i), 2, 3'(i), 0, i == 7, i == 7)));
    // LM R1,R2 with a two-cycle hold on the first micro-op, also back-to-back
    vecs.push_back(mk("lm_06_accept", 1, 1, 0, 8'h06, 3'd1, 0, 0, Z));
    vecs.push_back(mk("lm_06_hold1", 0, 0, 0, 8'h00, 3'd0, 1, 0, e_uop(1, 1, 1, 0, 1, 0, 0)));
    vecs.push_back(mk("lm_06_hold2", 0, 0, 0, 8'h00, 3'd0, 1, 0, e_uop(1, 1, 1, 0, 1, 0, 0)));
    vecs.push_back(mk("lm_06_uop0", 0, 0, 0, 8'h00, 3'd0, 0, 0, e_uop(1, 1, 1, 0, 1, 0, 0)));
    vecs.push_back(mk("lm_06_uop1", 0, 0, 0, 8'h00, 3'd0, 0, 0, e_uop(1, 2, 1, 1, 1, 1, 1)));
    vecs.push_back(mk("lm_06_after", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    // SM R4..R7 flushed in the second ISSUE cycle
    vecs.push_back(mk("sm_f0_accept", 1, 0, 1, 8'hF0, 3'd6, 0, 0, Z));
    vecs.push_back(mk("sm_f0_uop0", 0, 0, 0, 8'h00, 3'd0, 0, 0, e_uop(1, 4, 6, 0, 0, 0, 0)));
    vecs.push_back(mk("sm_f0_flush", 0, 0, 0, 8'h00, 3'd0, 0, 1, e_uop(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("sm_f0_after1", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    vecs.push_back(mk("sm_f0_after2", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    // flush beats hold
    vecs.push_back(mk("lm_03_accept", 1, 1, 0, 8'h03, 3'd0, 0, 0, Z));
    vecs.push_back(mk("lm_03_hold_flush", 0, 0, 0, 8'h00, 3'd0, 1, 1, e_uop(0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk("lm_03_after", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    // ignored starts
    vecs.push_back(mk("start_with_flush", 1, 1, 0, 8'h01, 3'd1, 0, 1, Z));
    vecs.push_back(mk("start_with_flush_n", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    vecs.push_back(mk("empty_list", 1, 1, 0, 8'h00, 3'd1, 0, 0, Z));
    vecs.push_back(mk("empty_list_n", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    vecs.push_back(mk("both_lm_sm", 1, 1, 1, 8'hFF, 3'd1, 0, 0, Z));
    vecs.push_back(mk("both_lm_sm_n", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    vecs.push_back(mk("neither_lm_sm", 1, 0, 0, 8'hFF, 3'd1, 0, 0, Z));
    vecs.push_back(mk("neither_lm_sm_n", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    // start is not sampled during ISSUE
    vecs.push_back(mk("lm_03b_accept", 1, 1, 0, 8'h03, 3'd4, 0, 0, Z));
    vecs.push_back(mk("lm_03b_uop0_start", 1, 0, 1, 8'hFF, 3'd7, 0, 0,
                      e_uop(1, 0, 4, 0, 1, 0, 0)));
    vecs.push_back(mk("lm_03b_uop1", 0, 0, 0, 8'h00, 3'd0, 0, 0, e_uop(1, 1, 4, 1, 1, 1, 1)));
    vecs.push_back(mk("lm_03b_after", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      expect_push(vecs[i].name, vecs[i].exp);
      #2 check_pop();
    end

    // asynchronous reset in the second ISSUE cycle of LM 8'hFF
    @(negedge clk);
    drive(mk("rst_accept", 1, 1, 0, 8'hFF, 3'd5, 0, 0, Z));
    expect_push("rst_seq_accept", Z);
    #2 check_pop();
    @(negedge clk);
    drive(mk("idle", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    expect_push("rst_seq_uop0", e_uop(1, 0, 5, 0, 1, 0, 0));
    #2 check_pop();
    @(negedge clk);
    expect_push("rst_seq_uop1", e_uop(1, 1, 5, 1, 1, 0, 0));
    #1 check_pop();
    #1 rst = 1'b0;
    expect_push("rst_async_drop", Z);
    #1 check_pop();
    @(negedge clk);
    rst = 1'b1;
    expect_push("post_rst_idle", Z);
    #2 check_pop();
    @(negedge clk);
    expect_push("post_rst_idle2", Z);
    #2 check_pop();
    @(negedge clk);
    drive(mk("rec_accept", 1, 1, 0, 8'h01, 3'd7, 0, 0, Z));
    expect_push("recover_accept", Z);
    #2 check_pop();
    @(negedge clk);
    drive(mk("idle", 0, 0, 0, 8'h00, 3'd0, 0, 0, Z));
    expect_push("recover_uop0", e_uop(1, 0, 7, 0, 1, 1, 1));
    #2 check_pop();
    @(negedge clk);
    expect_push("recover_after", Z);
    #2 check_pop();

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
